// File: rtl/dfd_apb_initiator.sv
// APB master for the DFD register block: one command in, one APB transfer out,
// one response back, with a PREADY timeout so a hung slave cannot stall the agent.
module dfd_apb_initiator #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        tmo_cnt_q;
  logic                    cmd_ready_q;
  logic                    busy_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;
  logic                    tmo_hit;

  // The counter holds the number of stalled ACCESS cycles already seen, so the
  // abort fires on the TIMEOUT_CYCLES-th stalled cycle.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (int'(tmo_cnt_q) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      tmo_cnt_q     <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer with an error without touching the bus.
              state_q       <= S_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= '0;
            end else begin
              state_q  <= S_SETUP;
              psel_q   <= 1'b1;
              paddr_q  <= cmd_addr;
              pwrite_q <= cmd_write;
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_write ? cmd_strb : '0;
            end
          end
        end

        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          tmo_cnt_q <= '0;
        end

        S_ACCESS: begin
          if (pready || tmo_hit) begin
            state_q       <= S_RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b1;
            // pready has priority over a timeout landing in the same cycle.
            rsp_err_q     <= pready ? pslverr : 1'b1;
            rsp_timeout_q <= !pready;
            rsp_rdata_q   <= (pready && !pwrite_q && !pslverr) ? prdata : '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;

endmodule

// File: doc/dfd_apb_initiator.md
Name: dfd_apb_initiator

Overview:
- Hardware APB master that turns single register commands into APB transfers toward the DFD register block.
- Used by on-chip agents (debug transport, trace controller) to read and write CLA/TR/MCR/DST/NTR CSRs.
- Carries one outstanding transfer at a time, with a valid/ready command channel and a valid/ready response channel.
- Bounds every access with a PREADY timeout so a hung slave cannot stall the agent.

Parameters:
- ADDR_WIDTH, 23, APB address width.
- DATA_WIDTH, 32, APB data width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when both valid and ready are high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
- rsp_err  out  1  slave error, timeout, or misaligned address
- rsp_timeout  out  1  abort caused by timeout
- busy  out  1  state is not IDLE
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  STRB_WIDTH  APB strobes
- pready  in  1  APB ready
- prdata  in  DATA_WIDTH  APB read data
- pslverr  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. All outputs come from registers.
- Reset values: all outputs 0, except cmd_ready=1 once reset_n is high, since state resets to IDLE.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1 and all APB outputs are 0.
  - On handshake, the block latches write, addr, wdata and strb.
  - If addr[1:0]!=0, the command is misaligned: go straight to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0, and drive no APB activity.
  - Otherwise go to SETUP.
- SETUP (one cycle):
  - psel=1, penable=0.
  - paddr, pwrite and pwdata are driven from the latched command.
  - pstrb = latched strb for writes, 0 for reads.
  - Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite, pwdata and pstrb are held stable.
  - Timeout counter clears on SETUP->ACCESS and increments each ACCESS cycle with pready=0.
  - In a cycle with pready=1: capture prdata for reads (0 for writes) and capture pslverr into rsp_err. Go to RESP, with psel=0 and penable=0 on the next edge.
  - pslverr is ignored when pready=0.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with pready still 0: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and drop psel/penable.
  - If pready and the timeout occur in the same cycle, pready wins (normal completion).
- RESP:
  - rsp_valid=1 and the response fields are held stable.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid=0 on the next cycle.
  - cmd_ready stays 0 until IDLE, so there is no command/response overlap.
- Latency:
  - Command accepted at edge T. Then psel=1 at T+1, penable=1 at T+2.
  - Zero-wait pready at T+2 gives rsp_valid at T+3.
  - Minimum command-to-command spacing is 4 cycles when rsp_ready is tied high.
- Reset mid-transfer: psel and penable drop to 0 asynchronously, and any pending response is discarded.
- busy is 1 whenever state is not IDLE.

Test Plan:
- Write: cmd write addr 0x000010, wdata 0xCEED1020, strb 0xF, pready=1 -> SETUP cycle with psel=1/penable=0/pstrb=0xF, then ACCESS, rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: read 0x000010, slave holds pready=0 for 3 ACCESS cycles then returns 0xCEED1020 -> rsp_rdata=0xCEED1020, pstrb=0 throughout, address stable through ACCESS.
- Slave error: read 0x7FFFFC, slave returns pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0. pslverr=1 with pready=0 on earlier cycles is ignored.
- Timeout: TIMEOUT_CYCLES=4, pready stuck at 0 -> exactly 4 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1. A second run with pready=1 on the 4th cycle completes normally with rsp_timeout=0.
- Misaligned address and backpressure: write to 0x000012 -> no psel pulse, rsp_err=1. Hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0; after release, the next command is accepted in IDLE.
- Reset mid-ACCESS: assert reset_n=0 during penable=1 -> psel/penable go to 0 without waiting for a clock, rsp_valid=0, and after deassertion cmd_ready=1.
